// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits; each bit held for OVERSAMPLE baud_clk cycles.
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 baud_clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in,
    input  logic                 send,
    output logic                 dout,
    output logic                 busy,
    output logic                 transmit_flag
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic [TICK_W-1:0]      tick;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   parity_bit;
    logic                   bit_end;

    assign bit_end = (tick == TICK_W'(OVERSAMPLE - 1));

    // dout is loaded one edge ahead with the value of the bit being entered
    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            tick          <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            parity_bit    <= 1'b0;
            dout          <= 1'b1;
            busy          <= 1'b0;
            transmit_flag <= 1'b0;
        end else begin
            transmit_flag <= 1'b0;
            tick          <= bit_end ? '0 : tick + 1'b1;
            case (state)
                IDLE: begin
                    tick    <= '0;
                    bit_cnt <= '0;
                    dout    <= 1'b1;
                    busy    <= 1'b0;
                    if (send) begin
                        shift_reg  <= in;
                        parity_bit <= (^in) ^ 1'(PARITY_ODD);
                        state      <= START;
                        dout       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        dout  <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                dout  <= parity_bit;
                            end else begin
                                state <= STOP;
                                dout  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            dout    <= shift_reg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        dout  <= 1'b1;
                    end
                end
                STOP: begin
                    // bit_cnt is reused here to count stop bits
                    if (bit_end) begin
                        if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                            state         <= IDLE;
                            bit_cnt       <= '0;
                            busy          <= 1'b0;
                            transmit_flag <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    dout  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E1, 8O2) checked cycle by
// cycle against a slot-based frame model.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic [2:0] send_v;
    wire  [2:0] dout_v;
    wire  [2:0] busy_v;
    wire  [2:0] flag_v;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    uart_tx dut0 (
        .baud_clk(clk), .reset(rst_n), .in(din), .send(send_v[0]),
        .dout(dout_v[0]), .busy(busy_v[0]), .transmit_flag(flag_v[0])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .baud_clk(clk), .reset(rst_n), .in(din), .send(send_v[1]),
        .dout(dout_v[1]), .busy(busy_v[1]), .transmit_flag(flag_v[1])
    );
    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
        .baud_clk(clk), .reset(rst_n), .in(din), .send(send_v[2]),
        .dout(dout_v[2]), .busy(busy_v[2]), .transmit_flag(flag_v[2])
    );

    function automatic int pen(int d);   return (d == 0) ? 0 : 1; endfunction
    function automatic int podd(int d);  return (d == 2) ? 1 : 0; endfunction
    function automatic int stops(int d); return (d == 2) ? 2 : 1; endfunction
    function automatic int frame_len(int d);
        return (1 + 8 + pen(d) + stops(d)) * 16;
    endfunction

    // expected line level k cycles after the accepting edge
    function automatic logic exp_line(int d, logic [7:0] v, int k);
        int slot;
        slot = k / 16;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return v[slot-1];
        if (pen(d) == 1 && slot == 9) return (^v) ^ 1'(podd(d));
        return 1'b1;
    endfunction

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, k, act, exp);
    endtask

    // skip_start: frame already accepted by a held send at the next edge
    task automatic run_frame(int d, logic [7:0] v, logic [7:0] nxt,
                             bit skip_start, bit hold, bit poke);
        int len;
        len = frame_len(d);
        if (skip_start) begin
            @(negedge clk);
        end else begin
            @(negedge clk);
            din       = v;
            send_v[d] = 1'b1;
            @(negedge clk);
        end
        if (!hold) send_v[d] = 1'b0;
        for (int k = 0; k < len; k++) begin
            chk($sformatf("dout[%0d]", d), k, 32'(dout_v[d]), 32'(exp_line(d, v, k)));
            chk($sformatf("busy[%0d]", d), k, 32'(busy_v[d]), 32'd1);
            chk($sformatf("flag[%0d]", d), k, 32'(flag_v[d]), 32'd0);
            if (poke && k == len / 2) begin
                din       = 8'hFF;
                send_v[d] = 1'b1;
            end
            if (poke && k == len / 2 + 1) send_v[d] = 1'b0;
            @(negedge clk);
        end
        chk($sformatf("end_flag[%0d]", d), len, 32'(flag_v[d]), 32'd1);
        chk($sformatf("end_busy[%0d]", d), len, 32'(busy_v[d]), 32'd0);
        chk($sformatf("end_dout[%0d]", d), len, 32'(dout_v[d]), 32'd1);
        if (hold) begin
            din = nxt;
        end else begin
            @(negedge clk);
            chk($sformatf("flag_once[%0d]", d), len + 1, 32'(flag_v[d]), 32'd0);
            chk($sformatf("idle_busy[%0d]", d), len + 1, 32'(busy_v[d]), 32'd0);
        end
    endtask

    typedef struct {
        int       d;
        logic [7:0] v;
        bit       poke;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 8'h35, 1'b0};
        tbl[1] = '{1, 8'h07, 1'b0};
        tbl[2] = '{2, 8'h07, 1'b0};
        tbl[3] = '{0, 8'hAA, 1'b1};
        tbl[4] = '{1, 8'h00, 1'b0};
        tbl[5] = '{2, 8'hFF, 1'b0};
        tbl[6] = '{2, 8'h5A, 1'b1};
        tbl[7] = '{1, 8'hC3, 1'b1};

        rst_n  = 1'b0;
        send_v = '0;
        din    = '0;
        #20;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_dout[%0d]", d), 0, 32'(dout_v[d]), 32'd1);
            chk($sformatf("rst_busy[%0d]", d), 0, 32'(busy_v[d]), 32'd0);
            chk($sformatf("rst_flag[%0d]", d), 0, 32'(flag_v[d]), 32'd0);
        end
        #32 rst_n = 1'b1;

        // idle for 2us with send low
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("idle_dout[%0d]", d), k, 32'(dout_v[d]), 32'd1);
                chk($sformatf("idle_busy[%0d]", d), k, 32'(busy_v[d]), 32'd0);
                chk($sformatf("idle_flag[%0d]", d), k, 32'(flag_v[d]), 32'd0);
            end
        end

        for (int i = 0; i < 8; i++)
            run_frame(tbl[i].d, tbl[i].v, 8'h00, 1'b0, 1'b0, tbl[i].poke);

        // held send: back-to-back frames one idle cycle apart
        run_frame(0, 8'hAA, 8'h55, 1'b0, 1'b1, 1'b0);
        run_frame(0, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0);
        run_frame(2, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
        run_frame(2, 8'hFF, 8'h5A, 1'b1, 1'b1, 1'b0);
        run_frame(2, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0);

        // reset during data bit 3 of 0x0F
        @(negedge clk);
        din       = 8'h0F;
        send_v[0] = 1'b1;
        @(negedge clk);
        send_v[0] = 1'b0;
        repeat (4 * 16 + 5) @(negedge clk);
        chk("mid_busy", 0, 32'(busy_v[0]), 32'd1);
        chk("mid_dout", 0, 32'(dout_v[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_dout", 0, 32'(dout_v[0]), 32'd1);
        chk("async_busy", 0, 32'(busy_v[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_noflag", k, 32'(flag_v[0]), 32'd0);
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            chk("post_rst_flag", k, 32'(flag_v[0]), 32'd0);
            chk("post_rst_dout", k, 32'(dout_v[0]), 32'd1);
        end
        run_frame(0, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int         d;
            logic [7:0] v;
            bit         p;
            d = $urandom_range(0, 2);
            v = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            run_frame(d, v, 8'h00, 1'b0, 1'b0, p);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
